// File: rtl/support_processing_unit_mc.sv
// Boundary support unit: stores exposed data per context/channel on a global
// switch and restores it later; a local switch bypasses the store entirely.
module support_processing_unit_mc #(
    parameter int ADDRESS_WIDTH       = 6,
    parameter int NUM_CONTEXTS        = 2,
    parameter int NUM_CHANNELS        = 4,
    parameter int STAGE_WIDTH         = 2,
    parameter int STAGE_IDLE          = 0,
    parameter int STAGE_WRITE_TO_MEM  = 1,
    parameter int STAGE_READ_FROM_MEM = 2
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [STAGE_WIDTH-1:0]                          global_stage,
    input  logic [NUM_CHANNELS*(ADDRESS_WIDTH+3)-1:0]       input_data,
    input  logic [NUM_CHANNELS-1:0]                         channel_enable,
    input  logic                                            local_context_switch,
    output logic [NUM_CHANNELS*(ADDRESS_WIDTH+3)-1:0]       output_data,
    output logic [((NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1)-1:0] context_id,
    output logic                                            read_miss
);

    localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3;
    localparam int W                 = NUM_CHANNELS * EXPOSED_DATA_SIZE;
    localparam int CW                = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;

    localparam logic [STAGE_WIDTH-1:0] ST_IDLE  = STAGE_WIDTH'(STAGE_IDLE);
    localparam logic [STAGE_WIDTH-1:0] ST_WRITE = STAGE_WIDTH'(STAGE_WRITE_TO_MEM);
    localparam logic [STAGE_WIDTH-1:0] ST_READ  = STAGE_WIDTH'(STAGE_READ_FROM_MEM);
    localparam logic [CW-1:0]          LAST_CTX = CW'(NUM_CONTEXTS - 1);

    logic [STAGE_WIDTH-1:0]  stage;
    logic [STAGE_WIDTH-1:0]  last_stage;
    logic                    last_switch_local;
    logic [W-1:0]            mem   [NUM_CONTEXTS];
    logic [NUM_CHANNELS-1:0] valid [NUM_CONTEXTS];

    logic         write_start;
    logic         read_start;
    logic         global_write;
    logic [W-1:0] restore_data;
    logic         restore_miss;

    // Actions fire only on the first cycle of a stage, never while it is held.
    assign write_start  = (stage == ST_WRITE) && (last_stage != ST_WRITE);
    assign read_start   = (stage == ST_READ)  && (last_stage != ST_READ);
    assign global_write = write_start && !local_context_switch;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        restore_data = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (valid[context_id][k]) begin
                restore_data[k*EXPOSED_DATA_SIZE +: EXPOSED_DATA_SIZE] =
                    mem[context_id][k*EXPOSED_DATA_SIZE +: EXPOSED_DATA_SIZE];
            end
        end
        restore_miss = ~&valid[context_id];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage             <= ST_IDLE;
            last_stage        <= ST_IDLE;
            output_data       <= '0;
            context_id        <= '0;
            read_miss         <= 1'b0;
            last_switch_local <= 1'b0;
            for (int c = 0; c < NUM_CONTEXTS; c++) begin
                valid[c] <= '0;
            end
        end else begin
            stage      <= global_stage;
            last_stage <= stage;
            read_miss  <= 1'b0;

            if (write_start) begin
                last_switch_local <= local_context_switch;
                if (local_context_switch) begin
                    output_data <= input_data;
                end else begin
                    valid[context_id] <= valid[context_id] | channel_enable;
                    context_id        <= (context_id == LAST_CTX) ? '0 : context_id + 1'b1;
                end
            end

            if (read_start && !last_switch_local) begin
                output_data <= restore_data;
                read_miss   <= restore_miss;
            end
        end
    end

    // NOTE: the data array is deliberately not reset; the valid bits alone
    // decide whether stored contents are ever observed.
    always_ff @(posedge clk) begin
        if (global_write) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (channel_enable[k]) begin
                    mem[context_id][k*EXPOSED_DATA_SIZE +: EXPOSED_DATA_SIZE] <=
                        input_data[k*EXPOSED_DATA_SIZE +: EXPOSED_DATA_SIZE];
                end
            end
        end
    end

endmodule

// File: tb/tb_support_processing_unit_mc.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized operations checked against a behavioural context-store model.
module tb_support_processing_unit_mc;

    localparam int AW   = 6;
    localparam int NCTX = 2;
    localparam int NCH  = 2;
    localparam int E    = AW + 3;
    localparam int W    = NCH * E;
    localparam int SW   = 2;
    localparam logic [SW-1:0] S_IDLE  = 2'd0;
    localparam logic [SW-1:0] S_WRITE = 2'd1;
    localparam logic [SW-1:0] S_READ  = 2'd2;

    logic           clk = 1'b0;
    logic           reset;
    logic [SW-1:0]  global_stage;
    logic [W-1:0]   input_data;
    logic [NCH-1:0] channel_enable;
    logic           local_context_switch;
    logic [W-1:0]   output_data;
    logic [0:0]     context_id;
    logic           read_miss;

    int checks = 0;
    int errors = 0;

    support_processing_unit_mc #(
        .ADDRESS_WIDTH(AW), .NUM_CONTEXTS(NCTX), .NUM_CHANNELS(NCH),
        .STAGE_WIDTH(SW), .STAGE_IDLE(0), .STAGE_WRITE_TO_MEM(1), .STAGE_READ_FROM_MEM(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .global_stage(global_stage),
        .input_data(input_data),
        .channel_enable(channel_enable),
        .local_context_switch(local_context_switch),
        .output_data(output_data),
        .context_id(context_id),
        .read_miss(read_miss)
    );

    always #5 clk = ~clk;

    // Behavioural model: what each context/channel holds and whether it was written.
    logic [E-1:0] m_mem   [NCTX][NCH];
    bit           m_valid [NCTX][NCH];
    int           m_ctx;
    logic [W-1:0] m_out;
    bit           m_miss;
    bit           m_last_local;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCTX; c++)
            for (int k = 0; k < NCH; k++) m_valid[c][k] = 0;
        m_ctx = 0; m_out = '0; m_miss = 0; m_last_local = 0;
    endtask

    task automatic model_op(input logic [SW-1:0] op, input bit loc,
                            input logic [NCH-1:0] en, input logic [W-1:0] data);
        m_miss = 0;
        if (op == S_WRITE) begin
            m_last_local = loc;
            if (loc) begin
                m_out = data;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    if (en[k]) begin
                        m_mem[m_ctx][k]   = data[k*E +: E];
                        m_valid[m_ctx][k] = 1;
                    end
                end
                m_ctx = (m_ctx + 1) % NCTX;
            end
        end else if (op == S_READ && !m_last_local) begin
            for (int k = 0; k < NCH; k++) begin
                m_out[k*E +: E] = m_valid[m_ctx][k] ? m_mem[m_ctx][k] : '0;
                if (!m_valid[m_ctx][k]) m_miss = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        global_stage = S_IDLE;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Applies one stage for `hold` cycles and checks both the action cycle and
    // the settled state afterwards against the model.
    task automatic run_op(input string name, input logic [SW-1:0] op, input bit loc,
                          input logic [NCH-1:0] en, input logic [W-1:0] data, input int hold);
        @(negedge clk);
        global_stage = op;
        local_context_switch = loc;
        channel_enable = en;
        input_data = data;
        for (int c = 1; c <= hold + 2; c++) begin
            @(negedge clk);
            if (c == hold) global_stage = S_IDLE;
            if (c == 1) begin
                check({name, " out before action"}, 32'(output_data), 32'(m_out));
            end
            if (c == 2) begin
                model_op(op, loc, en, data);
                check({name, " out"}, 32'(output_data), 32'(m_out));
                check({name, " ctx"}, 32'(context_id), 32'(m_ctx));
                check({name, " miss"}, 32'(read_miss), 32'(m_miss));
            end
        end
        check({name, " out settled"}, 32'(output_data), 32'(m_out));
        check({name, " ctx settled"}, 32'(context_id), 32'(m_ctx));
        check({name, " miss cleared"}, 32'(read_miss), 32'd0);
    endtask

    typedef struct {
        bit             rst_first;
        logic [SW-1:0]  op;
        bit             loc;
        logic [NCH-1:0] en;
        logic [W-1:0]   data;
        logic [W-1:0]   exp_out;
        int             exp_ctx;
        bit             exp_miss;
    } vec_t;

    vec_t vecs[10];

    initial begin
        reset = 1'b1;
        global_stage = S_IDLE;
        input_data = '0;
        channel_enable = '0;
        local_context_switch = 1'b0;
        model_reset();

        vecs[0] = '{1, S_WRITE, 0, 2'b11, 18'h1_2345, 18'h0,      1, 0};
        vecs[1] = '{0, S_WRITE, 0, 2'b11, 18'h0_ABCD, 18'h0,      0, 0};
        vecs[2] = '{0, S_READ,  0, 2'b00, 18'h0,      18'h1_2345, 0, 0};
        vecs[3] = '{0, S_WRITE, 1, 2'b11, 18'h3_0F0F, 18'h3_0F0F, 0, 0};
        vecs[4] = '{0, S_READ,  0, 2'b00, 18'h0,      18'h3_0F0F, 0, 0};
        vecs[5] = '{1, S_WRITE, 0, 2'b01, 18'h3_FFFF, 18'h0,      1, 0};
        vecs[6] = '{0, S_WRITE, 0, 2'b00, 18'h0,      18'h0,      0, 0};
        vecs[7] = '{0, S_READ,  0, 2'b00, 18'h0,      18'h0_01FF, 0, 1};
        vecs[8] = '{1, S_WRITE, 0, 2'b00, 18'h1_2345, 18'h0,      1, 0};
        vecs[9] = '{0, S_READ,  0, 2'b00, 18'h0,      18'h0,      1, 1};

        @(negedge clk);
        check("reset out", 32'(output_data), 32'd0);
        check("reset ctx", 32'(context_id), 32'd0);
        check("reset miss", 32'(read_miss), 32'd0);
        reset = 1'b0;

        // Directed vectors: expectations come straight from the table.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst_first) do_reset();
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].loc, vecs[i].en, vecs[i].data, 1);
            check($sformatf("vec%0d table out", i), 32'(output_data), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d table ctx", i), 32'(context_id), 32'(vecs[i].exp_ctx));
        end

        // Held WRITE stage: exactly one store and one context advance.
        do_reset();
        run_op("held write", S_WRITE, 0, 2'b11, 18'h2_AAAA, 5);
        check("held write ctx once", 32'(context_id), 32'd1);
        run_op("held read", S_READ, 0, 2'b00, 18'h0, 4);
        run_op("read back", S_WRITE, 0, 2'b00, 18'h0, 1);
        run_op("read held store", S_READ, 0, 2'b00, 18'h0, 1);
        check("held store data", 32'(output_data), 32'h2_AAAA);

        // Latency: stage change alone must not move the output on the first edge.
        @(negedge clk);
        global_stage = S_WRITE;
        local_context_switch = 1'b1;
        input_data = 18'h1_5A5A;
        @(negedge clk);
        check("latency edge1 out", 32'(output_data), 32'h2_AAAA);
        global_stage = S_IDLE;
        @(negedge clk);
        check("latency edge2 out", 32'(output_data), 32'h1_5A5A);
        model_op(S_WRITE, 1, 2'b00, 18'h1_5A5A);

        // Asynchronous reset between edges in the middle of a READ.
        @(negedge clk);
        global_stage = S_READ;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async rst out", 32'(output_data), 32'd0);
        check("async rst ctx", 32'(context_id), 32'd0);
        check("async rst miss", 32'(read_miss), 32'd0);
        @(negedge clk);
        global_stage = S_IDLE;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_op("fresh after rst", S_WRITE, 0, 2'b10, 18'h3_1234, 1);
        check("fresh strobe ctx", 32'(context_id), 32'd1);

        // Randomized operations against the model.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            logic [SW-1:0] op;
            op = ($urandom_range(0, 1) == 0) ? S_WRITE : S_READ;
            run_op($sformatf("rnd%0d", i), op, ($urandom_range(0, 3) == 0),
                   NCH'($urandom), W'($urandom), int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
